// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - scan-code constants, decoder state type and set-2 make-code to ASCII lookup
package kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} kbd_state_t;

    // shift=1 yields uppercase letters; returns 0 for codes with no ASCII meaning
    function automatic logic [7:0] scan_to_ascii(input logic [7:0] scan, input logic shift);
        logic [7:0] code;
        logic       isLetter;
        code     = 8'h00;
        isLetter = 1'b1;
        case (scan)
            8'h1C: code = 8'h41;  8'h32: code = 8'h42;  8'h21: code = 8'h43;  8'h23: code = 8'h44;
            8'h24: code = 8'h45;  8'h2B: code = 8'h46;  8'h34: code = 8'h47;  8'h33: code = 8'h48;
            8'h43: code = 8'h49;  8'h3B: code = 8'h4A;  8'h42: code = 8'h4B;  8'h4B: code = 8'h4C;
            8'h3A: code = 8'h4D;  8'h31: code = 8'h4E;  8'h44: code = 8'h4F;  8'h4D: code = 8'h50;
            8'h15: code = 8'h51;  8'h2D: code = 8'h52;  8'h1B: code = 8'h53;  8'h2C: code = 8'h54;
            8'h3C: code = 8'h55;  8'h2A: code = 8'h56;  8'h1D: code = 8'h57;  8'h22: code = 8'h58;
            8'h35: code = 8'h59;  8'h1A: code = 8'h5A;
            default: isLetter = 1'b0;
        endcase
        if (isLetter) begin
            if (!shift) code = code | 8'h20;
        end else begin
            case (scan)
                8'h45: code = 8'h30;  8'h16: code = 8'h31;  8'h1E: code = 8'h32;  8'h26: code = 8'h33;
                8'h25: code = 8'h34;  8'h2E: code = 8'h35;  8'h36: code = 8'h36;  8'h3D: code = 8'h37;
                8'h3E: code = 8'h38;  8'h46: code = 8'h39;
                8'h5A: code = 8'h0D;  8'h66: code = 8'h08;  8'h29: code = 8'h20;  8'h76: code = 8'h1B;
                default: code = 8'h00;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// rtl/kbd_fifo.sv - first-word fall-through FIFO with full/empty flags and dropped-write indication
module kbd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] wrData,
    input  logic             wrEn,
    output logic             full,
    output logic             dropped,
    output logic [WIDTH-1:0] rdData,
    output logic             empty,
    input  logic             rdEn
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doRead;
    logic             doWrite;

    assign empty   = (wrPtr == rdPtr);
    assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doRead  = rdEn && !empty;
    // a read in the same cycle frees the slot, so a write into a full FIFO still lands
    assign doWrite = wrEn && (!full || doRead);
    assign dropped = wrEn && full && !doRead;
    assign rdData  = empty ? '0 : mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + 1'b1;
            if (doRead)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) mem[wrPtr[AW-1:0]] <= wrData;
    end

endmodule

// File: rtl/kbd_key_decoder.sv
// rtl/kbd_key_decoder.sv - PS/2 set-2 scan byte to ASCII decoder with F0/E0 prefix FSM and ASCII FIFO
// Optional KBD_SHIFT_EN: track L/R shift and emit lowercase letters unless shift is held.
module kbd_key_decoder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       scanByte,
    input  logic             keyStrobe,
    input  logic             parityErr,
    output logic [7:0]       asciiData,
    output logic             asciiValid,
    input  logic             asciiReady,
    output logic             overflow,
    input  logic             clearOverflow,
    output logic [ERR_W-1:0] errCount
);

    logic       s1, s2, s3;
    logic       capture;
    kbd_state_t state, nextState;
    logic [7:0] makeCode;
    logic       makeValid;
    logic       shiftFlag;
    logic       shiftSet, shiftClr;
    logic       wrEn;
    logic [7:0] wrData;
    logic       fifoEmpty, fifoFull, fifoDropped;

    // The synchroniser keeps sampling through reset so s3 follows s2 and a strobe
    // level held across reset release is not mistaken for a fresh rising edge.
    always_ff @(posedge clk) begin
        s1 <= keyStrobe;
        s2 <= s1;
        s3 <= s2;
    end

    assign capture = s2 && !s3;

`ifdef KBD_SHIFT_EN
    logic shiftHeld;
    always_ff @(posedge clk) begin
        if (reset)         shiftHeld <= 1'b0;
        else if (shiftSet) shiftHeld <= 1'b1;
        else if (shiftClr) shiftHeld <= 1'b0;
    end
    assign shiftFlag = shiftHeld;
`else
    assign shiftFlag = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        makeCode  = scan_to_ascii(scanByte, shiftFlag);
        makeValid = 1'b0;
        shiftSet  = 1'b0;
        shiftClr  = 1'b0;
        if (capture) begin
            if (parityErr) begin
                nextState = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (scanByte == SC_BREAK)    nextState = BRK;
                        else if (scanByte == SC_EXT) nextState = EXT;
`ifdef KBD_SHIFT_EN
                        else if (scanByte == SC_LSHIFT || scanByte == SC_RSHIFT) shiftSet = 1'b1;
`endif
                        else makeValid = (makeCode != 8'h00);
                    end
                    BRK: begin
                        nextState = IDLE;
`ifdef KBD_SHIFT_EN
                        shiftClr = (scanByte == SC_LSHIFT || scanByte == SC_RSHIFT);
`endif
                    end
                    EXT: begin
                        nextState = (scanByte == SC_BREAK) ? EXT_BRK : IDLE;
                        if (scanByte == SC_ENTER) begin
                            makeCode  = 8'h0D;
                            makeValid = 1'b1;
                        end
                    end
                    default: nextState = IDLE;
                endcase
            end
        end
    end

    // Decoded makes are registered before the FIFO write, giving the fixed 4-cycle latency
    always_ff @(posedge clk) begin
        if (reset) begin
            wrEn   <= 1'b0;
            wrData <= 8'h00;
        end else begin
            wrEn   <= makeValid;
            wrData <= makeCode;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                                         errCount <= '0;
        else if (capture && parityErr && errCount != '1)   errCount <= errCount + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)              overflow <= 1'b0;
        else if (fifoDropped)   overflow <= 1'b1;
        else if (clearOverflow) overflow <= 1'b0;
    end

    kbd_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) uFifo (
        .clk    (clk),
        .reset  (reset),
        .wrData (wrData),
        .wrEn   (wrEn),
        .full   (fifoFull),
        .dropped(fifoDropped),
        .rdData (asciiData),
        .empty  (fifoEmpty),
        .rdEn   (asciiReady)
    );

    assign asciiValid = !fifoEmpty;

endmodule
